// File: rtl/io_pmp_pkg.sv
// ============================================================================
// io_pmp_pkg: address-checker FSM states and AXI burst encodings.
// Rev 1.0
// ============================================================================
`default_nettype none

package io_pmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_START = 3'd1,
    ST_CHK_END   = 3'd2,
    ST_FWD       = 3'd3,
    ST_DENY      = 3'd4
  } chk_state_t;

  localparam logic [1:0] C_BURST_FIXED = 2'b00;
  localparam logic [1:0] C_BURST_INCR  = 2'b01;
  localparam logic [1:0] C_BURST_WRAP  = 2'b10;
  localparam logic [1:0] C_BURST_RSVD  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/riscv.sv
// ============================================================================
// riscv: privilege-level and PMP access-kind types shared with the pmp unit.
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'b000,
    ACCESS_READ  = 3'b001,
    ACCESS_WRITE = 3'b010,
    ACCESS_EXEC  = 3'b100
  } pmp_access_t;

endpackage

`default_nettype wire

// File: rtl/axi_burst_range.sv
// ============================================================================
// axi_burst_range: first/last byte address of an AXI burst and legality flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_burst_range
  import io_pmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int PLEN       = 34
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [PLEN-1:0]       o_start,
  output logic [PLEN-1:0]       o_end,
  output logic                  o_illegal
);

  localparam int AW1 = ADDR_WIDTH + 1;

  logic [AW1-1:0] w_addr;
  logic [AW1-1:0] w_mask;
  logic [AW1-1:0] w_total;
  logic [AW1-1:0] w_start;
  logic [AW1-1:0] w_end;
  logic           w_wrap_len_ok;
  logic           w_page_cross;
  logic           w_out_of_range;

  // One extra bit so a range running off the top of the address space is
  // visible as an out-of-range end instead of silently wrapping to zero.
  assign w_addr  = {1'b0, i_addr};
  assign w_mask  = (AW1'(1) << i_size) - AW1'(1);
  assign w_total = AW1'({1'b0, i_len} + 9'd1) << i_size;

  always_comb begin
    w_start = w_addr;
    w_end   = (w_addr & ~w_mask) + w_total - AW1'(1);
    case (i_burst)
      C_BURST_FIXED: w_end = (w_addr & ~w_mask) + w_mask;
      C_BURST_WRAP: begin
        w_start = w_addr & ~(w_total - AW1'(1));
        w_end   = w_start + w_total - AW1'(1);
      end
      default: ;
    endcase
  end

  assign w_wrap_len_ok  = (i_len == 8'd1) || (i_len == 8'd3) ||
                          (i_len == 8'd7) || (i_len == 8'd15);
  assign w_page_cross   = (w_end[AW1-1:12] != w_start[AW1-1:12]);
  assign w_out_of_range = |(w_end >> PLEN);

  assign o_illegal = (i_burst == C_BURST_RSVD)
                   || ((i_burst == C_BURST_WRAP) && !w_wrap_len_ok)
                   || ((i_burst == C_BURST_INCR) && w_page_cross)
                   || w_out_of_range;

  assign o_start = w_start[PLEN-1:0];
  assign o_end   = w_end[PLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/axi_pmp_addr_check.sv
// ============================================================================
// axi_pmp_addr_check: checks both ends of one AXI burst against the PMP and
// forwards it downstream or diverts it to the error slave.   Rev 1.0
// ============================================================================
`default_nettype none

module axi_pmp_addr_check
  import io_pmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int PLEN       = 34
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [7:0]                req_len_i,
  input  logic [2:0]                req_size_i,
  input  logic [1:0]                req_burst_i,
  input  logic [ID_WIDTH-1:0]       req_id_i,
  input  riscv::pmp_access_t        access_type_i,
  input  riscv::priv_lvl_t          priv_lvl_i,
  output logic [PLEN-1:0]           pmp_addr_o,
  output riscv::pmp_access_t        pmp_access_type_o,
  output riscv::priv_lvl_t          pmp_priv_lvl_o,
  input  logic                      pmp_allow_i,
  output logic                      fwd_valid_o,
  input  logic                      fwd_ready_i,
  output logic [ADDR_WIDTH-1:0]     fwd_addr_o,
  output logic [7:0]                fwd_len_o,
  output logic [2:0]                fwd_size_o,
  output logic [1:0]                fwd_burst_o,
  output logic [ID_WIDTH-1:0]       fwd_id_o,
  output logic                      err_valid_o,
  input  logic                      err_ready_i,
  output logic [ID_WIDTH-1:0]       err_id_o,
  output logic [7:0]                err_len_o,
  output logic [15:0]               deny_count_o
);

  chk_state_t            r_state;
  chk_state_t            w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ID_WIDTH-1:0]   r_id;
  logic [PLEN-1:0]       r_start;
  logic [PLEN-1:0]       r_end;
  logic                  r_allow_start;
  logic [15:0]           r_deny_cnt;
  logic [PLEN-1:0]       w_start;
  logic [PLEN-1:0]       w_end;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_deny_entry;

  axi_burst_range #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PLEN       (PLEN)
  ) u_range (
    .i_addr    (req_addr_i),
    .i_len     (req_len_i),
    .i_size    (req_size_i),
    .i_burst   (req_burst_i),
    .o_start   (w_start),
    .o_end     (w_end),
    .o_illegal (w_illegal)
  );

  assign w_accept     = (r_state == ST_IDLE) && req_valid_i;
  assign w_deny_entry = (w_state_next == ST_DENY) && (r_state != ST_DENY);

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    pmp_addr_o   = '0;
    fwd_valid_o  = 1'b0;
    err_valid_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = rst_ni;
        if (req_valid_i) w_state_next = w_illegal ? ST_DENY : ST_CHK_START;
      end
      ST_CHK_START: begin
        pmp_addr_o   = r_start;
        w_state_next = ST_CHK_END;
      end
      ST_CHK_END: begin
        pmp_addr_o   = r_end;
        w_state_next = (r_allow_start && pmp_allow_i) ? ST_FWD : ST_DENY;
      end
      ST_FWD: begin
        fwd_valid_o = 1'b1;
        if (fwd_ready_i) w_state_next = ST_IDLE;
      end
      ST_DENY: begin
        err_valid_o = 1'b1;
        if (err_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_id          <= '0;
      r_start       <= '0;
      r_end         <= '0;
      r_allow_start <= 1'b0;
      r_deny_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= req_addr_i;
        r_len   <= req_len_i;
        r_size  <= req_size_i;
        r_burst <= req_burst_i;
        r_id    <= req_id_i;
        r_start <= w_start;
        r_end   <= w_end;
      end
      if (r_state == ST_CHK_START) r_allow_start <= pmp_allow_i;
      if (w_deny_entry && (r_deny_cnt != 16'hFFFF)) r_deny_cnt <= r_deny_cnt + 16'd1;
    end
  end

  assign pmp_access_type_o = access_type_i;
  assign pmp_priv_lvl_o    = priv_lvl_i;
  assign fwd_addr_o        = r_addr;
  assign fwd_len_o         = r_len;
  assign fwd_size_o        = r_size;
  assign fwd_burst_o       = r_burst;
  assign fwd_id_o          = r_id;
  assign err_id_o          = r_id;
  assign err_len_o         = r_len;
  assign deny_count_o      = r_deny_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_pmp_addr_check.sv
// ============================================================================
// tb_axi_pmp_addr_check: directed vector table plus backpressure/reset cases.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_pmp_addr_check;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic [2:0]  req_size_i;
  logic [1:0]  req_burst_i;
  logic [3:0]  req_id_i;
  riscv::pmp_access_t access_type_i;
  riscv::priv_lvl_t   priv_lvl_i;
  logic [33:0] pmp_addr_o;
  riscv::pmp_access_t pmp_access_type_o;
  riscv::priv_lvl_t   pmp_priv_lvl_o;
  logic        pmp_allow_i;
  logic        fwd_valid_o;
  logic        fwd_ready_i;
  logic [63:0] fwd_addr_o;
  logic [7:0]  fwd_len_o;
  logic [2:0]  fwd_size_o;
  logic [1:0]  fwd_burst_o;
  logic [3:0]  fwd_id_o;
  logic        err_valid_o;
  logic        err_ready_i;
  logic [3:0]  err_id_o;
  logic [7:0]  err_len_o;
  logic [15:0] deny_count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // PMP environment: TOR entry 0 covers [0, 0x1000_0000) for U-mode R/W;
  // M-mode has no locked entries and is allowed everywhere.
  assign pmp_allow_i = (pmp_priv_lvl_o == riscv::PRIV_LVL_M) || (pmp_addr_o < 34'h1000_0000);

  axi_pmp_addr_check #(.ADDR_WIDTH(64), .ID_WIDTH(4), .PLEN(34)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_addr_i        (req_addr_i),
    .req_len_i         (req_len_i),
    .req_size_i        (req_size_i),
    .req_burst_i       (req_burst_i),
    .req_id_i          (req_id_i),
    .access_type_i     (access_type_i),
    .priv_lvl_i        (priv_lvl_i),
    .pmp_addr_o        (pmp_addr_o),
    .pmp_access_type_o (pmp_access_type_o),
    .pmp_priv_lvl_o    (pmp_priv_lvl_o),
    .pmp_allow_i       (pmp_allow_i),
    .fwd_valid_o       (fwd_valid_o),
    .fwd_ready_i       (fwd_ready_i),
    .fwd_addr_o        (fwd_addr_o),
    .fwd_len_o         (fwd_len_o),
    .fwd_size_o        (fwd_size_o),
    .fwd_burst_o       (fwd_burst_o),
    .fwd_id_o          (fwd_id_o),
    .err_valid_o       (err_valid_o),
    .err_ready_i       (err_ready_i),
    .err_id_o          (err_id_o),
    .err_len_o         (err_len_o),
    .deny_count_o      (deny_count_o)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic        m_mode;
    logic        early;   // illegal range: straight to DENY, no lookup
    logic        fwd;     // 1 = forwarded, 0 = denied
    logic [33:0] exp_start;
    logic [33:0] exp_end;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    req_len_i   = v.len;
    req_size_i  = v.size;
    req_burst_i = v.burst;
    req_id_i    = v.id;
    priv_lvl_i  = v.m_mode ? riscv::PRIV_LVL_M : riscv::PRIV_LVL_U;
  endtask

  // Checks the outcome cycle (valid, fields, counter) and completes the handshake.
  task automatic finish_out(input vec_t v, input string tag);
    if (!v.fwd) exp_cnt++;
    chk({tag, " fwd_valid"}, 64'(fwd_valid_o), 64'(v.fwd));
    chk({tag, " err_valid"}, 64'(err_valid_o), 64'(!v.fwd));
    chk({tag, " deny_count"}, 64'(deny_count_o), 64'(exp_cnt));
    if (v.fwd) begin
      chk({tag, " fwd_addr"}, fwd_addr_o, v.addr);
      chk({tag, " fwd_len/size/burst/id"},
          64'({fwd_len_o, fwd_size_o, fwd_burst_o, fwd_id_o}),
          64'({v.len, v.size, v.burst, v.id}));
      fwd_ready_i = 1'b1;
    end else begin
      chk({tag, " err_id/len"}, 64'({err_id_o, err_len_o}), 64'({v.id, v.len}));
      err_ready_i = 1'b1;
    end
    @(negedge clk);
    fwd_ready_i = 1'b0;
    err_ready_i = 1'b0;
    chk({tag, " idle after handshake"},
        64'({req_ready_o, fwd_valid_o, err_valid_o}), 64'(3'b100));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive_req(v);
    #1 chk({tag, " req_ready idle"}, 64'(req_ready_o), 64'd1);
    @(negedge clk);                       // cycle 1
    req_valid_i = 1'b0;
    chk({tag, " req_ready busy"}, 64'(req_ready_o), 64'd0);
    if (v.early) begin
      chk({tag, " no lookup"}, 64'(pmp_addr_o), 64'd0);
      finish_out(v, tag);
    end else begin
      chk({tag, " c1 valids"}, 64'({fwd_valid_o, err_valid_o}), 64'd0);
      chk({tag, " pmp start"}, 64'(pmp_addr_o), 64'(v.exp_start));
      @(negedge clk);                     // cycle 2
      chk({tag, " pmp end"}, 64'(pmp_addr_o), 64'(v.exp_end));
      chk({tag, " c2 valids"}, 64'({fwd_valid_o, err_valid_o}), 64'd0);
      @(negedge clk);                     // cycle 3
      finish_out(v, tag);
    end
  endtask

  initial begin
    vec_t v;
    // addr, len, size, burst, id, M, early, fwd, start, end
    vecs[0]  = '{64'h0000_0000_0FFF_F000, 8'd15,  3'd3, 2'b01, 4'h1, 1'b0, 1'b0, 1'b1, 34'h0_0FFF_F000, 34'h0_0FFF_F07F};
    vecs[1]  = '{64'h0000_0000_0FFF_FFF8, 8'd1,   3'd3, 2'b01, 4'h2, 1'b0, 1'b1, 1'b0, 34'h0, 34'h0};
    vecs[2]  = '{64'h0000_0000_0000_0034, 8'd3,   3'd2, 2'b10, 4'h3, 1'b0, 1'b0, 1'b1, 34'h0_0000_0030, 34'h0_0000_003F};
    vecs[3]  = '{64'h0000_0000_1000_0000, 8'd0,   3'd2, 2'b01, 4'h4, 1'b0, 1'b0, 1'b0, 34'h0_1000_0000, 34'h0_1000_0003};
    vecs[4]  = '{64'h0000_0001_0000_0000, 8'd0,   3'd2, 2'b01, 4'h5, 1'b1, 1'b0, 1'b1, 34'h1_0000_0000, 34'h1_0000_0003};
    vecs[5]  = '{64'h0000_0004_0000_0000, 8'd0,   3'd2, 2'b01, 4'h6, 1'b1, 1'b1, 1'b0, 34'h0, 34'h0};
    vecs[6]  = '{64'h0000_0000_0000_1003, 8'd7,   3'd2, 2'b00, 4'h7, 1'b0, 1'b0, 1'b1, 34'h0_0000_1003, 34'h0_0000_1003};
    vecs[7]  = '{64'h0000_0000_0000_0100, 8'd2,   3'd2, 2'b10, 4'h8, 1'b0, 1'b1, 1'b0, 34'h0, 34'h0};
    vecs[8]  = '{64'h0000_0000_0000_0100, 8'd0,   3'd0, 2'b11, 4'h9, 1'b0, 1'b1, 1'b0, 34'h0, 34'h0};
    vecs[9]  = '{64'h0000_0000_0FFF_FF00, 8'd255, 3'd0, 2'b01, 4'hA, 1'b0, 1'b0, 1'b1, 34'h0_0FFF_FF00, 34'h0_0FFF_FFFF};
    vecs[10] = '{64'h0000_0000_0FFF_FFFC, 8'd0,   3'd3, 2'b01, 4'hB, 1'b0, 1'b0, 1'b1, 34'h0_0FFF_FFFC, 34'h0_0FFF_FFFF};
    vecs[11] = '{64'h0000_0000_0000_1078, 8'd15,  3'd3, 2'b10, 4'hC, 1'b0, 1'b0, 1'b1, 34'h0_0000_1000, 34'h0_0000_107F};
    vecs[12] = '{64'h0000_0003_FFFF_F000, 8'd0,   3'd2, 2'b01, 4'hD, 1'b1, 1'b0, 1'b1, 34'h3_FFFF_F000, 34'h3_FFFF_F003};
    vecs[13] = '{64'hFFFF_FFFF_FFFF_FFF0, 8'd0,   3'd3, 2'b00, 4'hE, 1'b1, 1'b1, 1'b0, 34'h0, 34'h0};
    vecs[14] = '{64'h0000_0003_FFFF_FFF0, 8'd3,   3'd2, 2'b10, 4'hF, 1'b1, 1'b0, 1'b1, 34'h3_FFFF_FFF0, 34'h3_FFFF_FFFF};

    rst_ni        = 1'b0;
    req_valid_i   = 1'b0;
    req_addr_i    = '0;
    req_len_i     = '0;
    req_size_i    = '0;
    req_burst_i   = '0;
    req_id_i      = '0;
    access_type_i = riscv::ACCESS_READ;
    priv_lvl_i    = riscv::PRIV_LVL_U;
    fwd_ready_i   = 1'b0;
    err_ready_i   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset req_ready", 64'(req_ready_o), 64'd0);
    chk("reset valids", 64'({fwd_valid_o, err_valid_o}), 64'd0);
    chk("reset deny_count", 64'(deny_count_o), 64'd0);
    chk("reset pmp_addr", 64'(pmp_addr_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", 64'(req_ready_o), 64'd1);
    chk("pmp access passthrough", 64'(pmp_access_type_o), 64'(riscv::ACCESS_READ));
    access_type_i = riscv::ACCESS_WRITE;
    priv_lvl_i    = riscv::PRIV_LVL_S;
    #1;
    chk("pmp access passthrough W", 64'(pmp_access_type_o), 64'(riscv::ACCESS_WRITE));
    chk("pmp priv passthrough", 64'(pmp_priv_lvl_o), 64'(riscv::PRIV_LVL_S));
    access_type_i = riscv::ACCESS_READ;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: forward held 5 cycles while the next request waits.
    @(negedge clk);
    drive_req(vecs[0]);
    @(negedge clk);
    drive_req(vecs[2]);
    chk("bp c1 start", 64'(pmp_addr_o), 64'(vecs[0].exp_start));
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold%0d fwd_valid", k), 64'(fwd_valid_o), 64'd1);
      chk($sformatf("bp hold%0d fields", k),
          64'({fwd_addr_o[31:0], fwd_len_o, fwd_id_o}),
          64'({vecs[0].addr[31:0], vecs[0].len, vecs[0].id}));
      chk($sformatf("bp hold%0d req_ready", k), 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    fwd_ready_i = 1'b1;
    @(negedge clk);
    fwd_ready_i = 1'b0;
    chk("bp after hs fwd_valid", 64'(fwd_valid_o), 64'd0);
    chk("bp after hs req_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("bp second accepted", 64'(pmp_addr_o), 64'(vecs[2].exp_start));
    @(negedge clk);
    chk("bp second end", 64'(pmp_addr_o), 64'(vecs[2].exp_end));
    @(negedge clk);
    finish_out(vecs[2], "bp2");

    // Reset while in CHK_END drops the request and clears the counter.
    @(negedge clk);
    drive_req(vecs[0]);
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst chk_end pmp", 64'(pmp_addr_o), 64'(vecs[0].exp_end));
    rst_ni = 1'b0;
    @(negedge clk);
    exp_cnt = 0;
    chk("rst valids", 64'({fwd_valid_o, err_valid_o}), 64'd0);
    chk("rst deny_count", 64'(deny_count_o), 64'd0);
    chk("rst req_ready", 64'(req_ready_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst released valids", 64'({fwd_valid_o, err_valid_o, req_ready_o}), 64'(3'b001));
    v = vecs[1];
    run_vec(v, "post-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/axi_pmp_addr_check.md
# axi_pmp_addr_check

Address-channel checker for one AXI direction (AR or AW) of the IO-PMP. It accepts one burst request at a time and derives the burst's first and last byte address. It runs both through the shared combinational `pmp` unit in two consecutive cycles, then either forwards the unchanged request downstream or diverts it to the error-response path.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: AXI address width.
- `ID_WIDTH`, 4: AXI ID width.
- `PLEN`, 34: physical address width checked by the PMP; must satisfy PLEN <= ADDR_WIDTH.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_valid_i` / `req_ready_o`  in/out  1  upstream handshake.
- `req_addr_i`  in  ADDR_WIDTH  AxADDR.
- `req_len_i`  in  8  AxLEN.
- `req_size_i`  in  3  AxSIZE.
- `req_burst_i`  in  2  AxBURST.
- `req_id_i`  in  ID_WIDTH  AxID.
- `access_type_i`  in  riscv::pmp_access_t  access kind of this channel (R for AR, W for AW).
- `priv_lvl_i`  in  riscv::priv_lvl_t  privilege level applied to device accesses.
- `pmp_addr_o`  out  PLEN  address presented to `pmp.addr_i`.
- `pmp_access_type_o`  out  riscv::pmp_access_t  to `pmp.access_type_i`.
- `pmp_priv_lvl_o`  out  riscv::priv_lvl_t  to `pmp.priv_lvl_i`.
- `pmp_allow_i`  in  1  `pmp.allow_o`.
- `fwd_valid_o` / `fwd_ready_i`  out/in  1  downstream handshake.
- `fwd_addr_o`, `fwd_len_o`, `fwd_size_o`, `fwd_burst_o`, `fwd_id_o`  out  as request  accepted request, unchanged.
- `err_valid_o` / `err_ready_i`  out/in  1  error-slave handshake.
- `err_id_o`  out  ID_WIDTH  ID to answer with SLVERR.
- `err_len_o`  out  8  beat count − 1.
- `deny_count_o`  out  16  saturating count of denied requests.

## Operation
- FSM states: IDLE, CHK_START, CHK_END, FWD, DENY.
- IDLE:
  - `req_ready_o` is 1 (0 while `rst_ni` is low).
  - On handshake, register the request fields and the computed `start`/`end` range.
  - Go to CHK_START if the range is legal, else to DENY.
- Range rules, all computed in ADDR_WIDTH+1 bits, with mask = 2^size − 1 and total = (len+1) << size:
  - FIXED: start = addr; end = (addr & ~mask) + mask.
  - INCR: start = addr; end = (addr & ~mask) + total − 1.
  - WRAP: start = addr & ~(total−1); end = start + total − 1.
- A request is illegal when any of these holds:
  - burst = 2'b11;
  - WRAP with len ∉ {1,3,7,15};
  - INCR with end[ADDR_WIDTH:12] ≠ start[ADDR_WIDTH:12] (4 KiB crossing);
  - any bit of `end` at position ≥ PLEN is set.
- CHK_START: `pmp_addr_o` = start[PLEN-1:0]; register `pmp_allow_i`; go to CHK_END.
- CHK_END: `pmp_addr_o` = end[PLEN-1:0]. Go to FWD if both samples were 1, else to DENY.
- FWD: `fwd_valid_o` = 1 with the registered fields; on `fwd_ready_i` go to IDLE.
- DENY: `err_valid_o` = 1, with `err_len_o` = registered len; on `err_ready_i` go to IDLE.
- `deny_count_o` increments by 1 on each DENY entry and saturates at 0xFFFF.
- `pmp_access_type_o` and `pmp_priv_lvl_o` are combinational copies of `access_type_i` and `priv_lvl_i`.
- `pmp_addr_o` is 0 outside the check states.
- Endpoint-only checking is sound because the system programs PMP with granularity ≥ 4 KiB. A legal burst then lies inside one 4 KiB page, which is covered by a single PMP region.
- PMP configuration and `priv_lvl_i` must be held stable while a request is in flight. The block does not re-check on change.

## Timing
- Reset values: `req_ready_o`=0 during reset and 1 in the first cycle after; all valids 0; `deny_count_o`=0; state IDLE.
- Legal request accepted in cycle 0:
  - CHK_START in cycle 1, CHK_END in cycle 2.
  - `fwd_valid_o` or `err_valid_o` rises in cycle 3.
- Illegal request accepted in cycle 0: `err_valid_o` rises in cycle 1, with no PMP lookup.
- Valid outputs stay asserted and their fields stay stable until the handshake completes.
- `req_ready_o` is 0 from acceptance through the output handshake, so the next acceptance is possible at the earliest one cycle after the output handshake.
- `rst_ni` low in any state: the next edge returns to IDLE and clears all registers and the counter. An in-flight request is dropped.

## Structure
- Shared package `io_pmp_pkg`: FSM state enum and the AXI burst encodings FIXED/INCR/WRAP/RSVD.
- Sub-module `axi_burst_range`: combinational start/end/illegal computation, reused by the AR and AW instances.

## Test plan
Common setup for scenarios 1–4: PMP entry 0 is TOR with top 0x1000_0000 (`conf_addr` 0x0400_0000), R/W, U-mode.
1. INCR, addr 0x0FFF_F000, len 15, size 3 -> `pmp_addr_o` is 0x0FFF_F000 in cycle 1 and 0x0FFF_F07F in cycle 2; `fwd_valid_o` in cycle 3 with identical fields; count 0.
2. INCR, addr 0x0FFF_FFF8, len 1, size 3 (4 KiB crossing) -> `err_valid_o` in cycle 1 with `err_len_o`=1; count 1; no check states visited.
3. WRAP, addr 0x0000_0034, len 3, size 2 -> checks 0x0000_0030 then 0x0000_003F; forwarded.
4. U-mode, INCR, addr 0x1000_0000, len 0, size 2 -> start denied; DENY in cycle 3; count increments.
5. M-mode, no locked entries: addr 0x1_0000_0000 is forwarded; addr 0x4_0000_0000 (PLEN 34) is denied in cycle 1.
6. Hold `fwd_ready_i` low 5 cycles -> valid and fields stable, `req_ready_o`=0, next request accepted the cycle after the handshake. Separately, assert `rst_ni`=0 during CHK_END -> all valids 0 and count 0 in the next cycle.
